// File: rtl/axi4_lite_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi4_lite_pkg
// Description : Shared AXI4-Lite response codes and FSM state types.
// Revision    : 1.0 - initial release
// ============================================================================
package axi4_lite_pkg;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b10
    } axi_resp_t;

    typedef enum logic [0:0] {
        WR_IDLE = 1'b0,
        WR_RESP = 1'b1
    } wr_state_t;

    typedef enum logic [0:0] {
        RD_IDLE = 1'b0,
        RD_RESP = 1'b1
    } rd_state_t;

endpackage
`default_nettype wire

// File: rtl/axi4_lite_if.sv
`default_nettype none
// ============================================================================
// Module      : axi4_lite_if
// Description : Unified AXI4-Lite bus bundle with master and slave views.
// Revision    : 1.0 - initial release
// ============================================================================
interface axi4_lite_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   AWADDR;
    logic                    AWVALID;
    logic                    AWREADY;
    logic [DATA_WIDTH-1:0]   WDATA;
    logic [DATA_WIDTH/8-1:0] WSTRB;
    logic                    WVALID;
    logic                    WREADY;
    logic [1:0]              BRESP;
    logic                    BVALID;
    logic                    BREADY;
    logic [ADDR_WIDTH-1:0]   ARADDR;
    logic                    ARVALID;
    logic                    ARREADY;
    logic [DATA_WIDTH-1:0]   RDATA;
    logic [1:0]              RRESP;
    logic                    RVALID;
    logic                    RREADY;

    modport slave (
        input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
        output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );

    modport master (
        output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
        input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );
endinterface
`default_nettype wire

// File: rtl/axi4_lite_regfile.sv
`default_nettype none
// ============================================================================
// Module      : axi4_lite_regfile
// Description : Byte-strobe writable register file with async read mux.
// Revision    : 1.0 - initial release
// ============================================================================
module axi4_lite_regfile #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           i_wr_en,
    input  logic [$clog2(NUM_REGS)-1:0]    i_wr_idx,
    input  logic [DATA_WIDTH-1:0]          i_wr_data,
    input  logic [DATA_WIDTH/8-1:0]        i_wr_strb,
    input  logic [$clog2(NUM_REGS)-1:0]    i_rd_idx,
    output logic [DATA_WIDTH-1:0]          o_rd_data,
    output logic [NUM_REGS*DATA_WIDTH-1:0] o_reg_q
);
    localparam int c_strb_w = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] r_mem [NUM_REGS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_wr_en) begin
            for (int b = 0; b < c_strb_w; b++) begin
                if (i_wr_strb[b]) begin
                    r_mem[i_wr_idx][b*8 +: 8] <= i_wr_data[b*8 +: 8];
                end
            end
        end
    end

    assign o_rd_data = r_mem[i_rd_idx];

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign o_reg_q[g*DATA_WIDTH +: DATA_WIDTH] = r_mem[g];
    end
endmodule
`default_nettype wire

// File: rtl/axi4_lite_slave.sv
`default_nettype none
// ============================================================================
// Module      : axi4_lite_slave
// Description : AXI4-Lite responder with independent write/read FSMs over a
//               strobe-writable register file.
// Revision    : 1.0 - initial release
// ============================================================================
module axi4_lite_slave
    import axi4_lite_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    axi4_lite_if.slave                     slave_if,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
    output logic [NUM_REGS-1:0]            wr_pulse
);
    localparam int c_strb_w   = DATA_WIDTH / 8;
    localparam int c_addr_lsb = $clog2(c_strb_w);
    localparam int c_idx_w    = $clog2(NUM_REGS);

    wr_state_t               r_wr_state, w_wr_state_nxt;
    rd_state_t               r_rd_state, w_rd_state_nxt;
    logic                    r_aw_held, r_w_held;
    logic [ADDR_WIDTH-1:0]   r_awaddr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [c_strb_w-1:0]     r_wstrb;
    axi_resp_t               r_bresp, r_rresp;
    logic [DATA_WIDTH-1:0]   r_rdata;
    logic [NUM_REGS-1:0]     r_wr_pulse;

    // Readies depend only on registered state, never on incoming VALIDs.
    logic w_aw_ready, w_w_ready, w_ar_ready;
    assign w_aw_ready = (r_wr_state == WR_IDLE) && !r_aw_held;
    assign w_w_ready  = (r_wr_state == WR_IDLE) && !r_w_held;
    assign w_ar_ready = (r_rd_state == RD_IDLE);

    logic w_aw_fire, w_w_fire, w_ar_fire, w_commit;
    assign w_aw_fire = slave_if.AWVALID && w_aw_ready;
    assign w_w_fire  = slave_if.WVALID && w_w_ready;
    assign w_ar_fire = slave_if.ARVALID && w_ar_ready;
    assign w_commit  = (r_wr_state == WR_IDLE) && (w_aw_fire || r_aw_held) && (w_w_fire || r_w_held);

    logic [ADDR_WIDTH-1:0] w_wr_addr, w_wr_word, w_rd_word;
    logic [DATA_WIDTH-1:0] w_wr_data, w_rd_data;
    logic [c_strb_w-1:0]   w_wr_strb;
    logic [c_idx_w-1:0]    w_wr_idx, w_rd_idx;
    logic                  w_wr_in_range, w_rd_in_range, w_wr_en;

    assign w_wr_addr     = r_aw_held ? r_awaddr : slave_if.AWADDR;
    assign w_wr_data     = r_w_held  ? r_wdata  : slave_if.WDATA;
    assign w_wr_strb     = r_w_held  ? r_wstrb  : slave_if.WSTRB;
    assign w_wr_word     = w_wr_addr >> c_addr_lsb;
    assign w_wr_idx      = w_wr_word[c_idx_w-1:0];
    assign w_wr_in_range = (w_wr_word >> c_idx_w) == '0;
    assign w_wr_en       = w_commit && w_wr_in_range;

    assign w_rd_word     = slave_if.ARADDR >> c_addr_lsb;
    assign w_rd_idx      = w_rd_word[c_idx_w-1:0];
    assign w_rd_in_range = (w_rd_word >> c_idx_w) == '0;

    axi4_lite_regfile #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_REGS   (NUM_REGS)
    ) u_regfile (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (w_wr_en),
        .i_wr_idx  (w_wr_idx),
        .i_wr_data (w_wr_data),
        .i_wr_strb (w_wr_strb),
        .i_rd_idx  (w_rd_idx),
        .o_rd_data (w_rd_data),
        .o_reg_q   (reg_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_state <= WR_IDLE;
            r_rd_state <= RD_IDLE;
        end else begin
            r_wr_state <= w_wr_state_nxt;
            r_rd_state <= w_rd_state_nxt;
        end
    end

    always_comb begin
        w_wr_state_nxt = r_wr_state;
        case (r_wr_state)
            WR_IDLE: if (w_commit)         w_wr_state_nxt = WR_RESP;
            WR_RESP: if (slave_if.BREADY)  w_wr_state_nxt = WR_IDLE;
            default:                       w_wr_state_nxt = WR_IDLE;
        endcase
    end

    always_comb begin
        w_rd_state_nxt = r_rd_state;
        case (r_rd_state)
            RD_IDLE: if (w_ar_fire)        w_rd_state_nxt = RD_RESP;
            RD_RESP: if (slave_if.RREADY)  w_rd_state_nxt = RD_IDLE;
            default:                       w_rd_state_nxt = RD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_aw_held  <= 1'b0;
            r_w_held   <= 1'b0;
            r_awaddr   <= '0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_bresp    <= RESP_OKAY;
            r_wr_pulse <= '0;
        end else begin
            r_wr_pulse <= w_wr_en ? (NUM_REGS'(1) << w_wr_idx) : '0;
            if (w_commit) begin
                r_aw_held <= 1'b0;
                r_w_held  <= 1'b0;
                r_bresp   <= w_wr_in_range ? RESP_OKAY : RESP_SLVERR;
            end else begin
                if (w_aw_fire) begin
                    r_aw_held <= 1'b1;
                    r_awaddr  <= slave_if.AWADDR;
                end
                if (w_w_fire) begin
                    r_w_held <= 1'b1;
                    r_wdata  <= slave_if.WDATA;
                    r_wstrb  <= slave_if.WSTRB;
                end
            end
        end
    end

    // Read data is captured from the pre-write register contents at the AR edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= '0;
            r_rresp <= RESP_OKAY;
        end else if (w_ar_fire) begin
            r_rdata <= w_rd_in_range ? w_rd_data : '0;
            r_rresp <= w_rd_in_range ? RESP_OKAY : RESP_SLVERR;
        end
    end

    assign slave_if.AWREADY = w_aw_ready;
    assign slave_if.WREADY  = w_w_ready;
    assign slave_if.BVALID  = (r_wr_state == WR_RESP);
    assign slave_if.BRESP   = r_bresp;
    assign slave_if.ARREADY = w_ar_ready;
    assign slave_if.RVALID  = (r_rd_state == RD_RESP);
    assign slave_if.RDATA   = r_rdata;
    assign slave_if.RRESP   = r_rresp;
    assign wr_pulse         = r_wr_pulse;
endmodule
`default_nettype wire
